alu_rs: RTL and testbench



---
 rtl/mips_pkg.sv | 38 +++
 rtl/prio_enc_lowest.sv | 24 ++
 rtl/alu_rs.sv | 141 ++++++++++++++
 tb/tb_alu_rs.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS core's out-of-order back end.
package mips_pkg;

  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;
  localparam int OP_W   = 6;

  // A tag of zero means the operand value is already present.
  localparam logic [TAG_W-1:0] TAG_NONE = 5'd0;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } operand_t;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   opcode;
    logic [TAG_W-1:0]  dest_tag;
    operand_t          src1;
    operand_t          src2;
  } rs_entry_t;

  // Capture a CDB broadcast into a waiting operand; ready operands never match.
  function automatic operand_t snoop_operand(input operand_t          opnd,
                                             input logic              cdb_valid,
                                             input logic [TAG_W-1:0]  cdb_tag,
                                             input logic [DATA_W-1:0] cdb_data);
    operand_t res;
    res = opnd;
    if (cdb_valid && (opnd.tag != TAG_NONE) && (opnd.tag == cdb_tag)) begin
      res.tag = TAG_NONE;
      res.val = cdb_data;
    end
    return res;
  endfunction

endpackage

// File: rtl/prio_enc_lowest.sv
// Lowest-set-bit priority encoder: index of the lowest request and a found flag.
module prio_enc_lowest #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]         req,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     found
);

  localparam int IDX_W = $clog2(WIDTH);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: holds decoded ops, snoops the CDB
// for missing operands and dispatches one ready op at a time via start/done.
module alu_rs
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [OP_W-1:0]            issue_opcode,
  input  logic [TAG_W-1:0]           issue_src1_tag,
  input  logic [TAG_W-1:0]           issue_src2_tag,
  input  logic [DATA_W-1:0]          issue_src1_val,
  input  logic [DATA_W-1:0]          issue_src2_val,
  input  logic [TAG_W-1:0]           issue_dest_tag,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  output logic                       alu_start,
  output logic [OP_W-1:0]            alu_opcode,
  output logic [DATA_W-1:0]          alu_op1,
  output logic [DATA_W-1:0]          alu_op2,
  output logic [TAG_W-1:0]           alu_dest_tag,
  input  logic                       alu_done,
  output logic [$clog2(DEPTH+1)-1:0] rs_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  rs_entry_t        entries [DEPTH];
  logic             busy;
  logic [DEPTH-1:0] free_vec;
  logic [DEPTH-1:0] ready_vec;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             free_found;
  logic             sel_found;
  logic             alloc;
  logic             dispatch;
  rs_entry_t        new_entry;

  // Free and ready masks come from registered state only (ready is pre-snoop).
  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_vec[i]  = !entries[i].valid;
      ready_vec[i] = entries[i].valid &&
                     (entries[i].src1.tag == TAG_NONE) &&
                     (entries[i].src2.tag == TAG_NONE);
    end
  end

  prio_enc_lowest #(.WIDTH(DEPTH)) u_free_enc (
    .req   (free_vec),
    .idx   (free_idx),
    .found (free_found)
  );

  prio_enc_lowest #(.WIDTH(DEPTH)) u_ready_enc (
    .req   (ready_vec),
    .idx   (sel_idx),
    .found (sel_found)
  );

  assign issue_ready = !rst && free_found;
  assign alloc       = issue_valid && issue_ready;
  // A done arriving this edge frees the ALU in time for a same-edge dispatch.
  assign dispatch    = !rst && sel_found && (!busy || alu_done);

  // Build the incoming entry, bypassing a same-cycle broadcast into its sources.
  always_comb begin
    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.opcode   = issue_opcode;
    new_entry.dest_tag = issue_dest_tag;
    new_entry.src1     = snoop_operand(operand_t'{tag: issue_src1_tag, val: issue_src1_val},
                                       cdb_valid, cdb_tag, cdb_data);
    new_entry.src2     = snoop_operand(operand_t'{tag: issue_src2_tag, val: issue_src2_val},
                                       cdb_valid, cdb_tag, cdb_data);
  end

  // Occupancy is the population count of the valid bits.
  always_comb begin
    rs_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rs_count = rs_count + CNT_W'(entries[i].valid);
    end
  end

  // Entry array: snoop, free on dispatch, write on allocate.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entries[i].valid) begin
          entries[i].src1 <= snoop_operand(entries[i].src1, cdb_valid, cdb_tag, cdb_data);
          entries[i].src2 <= snoop_operand(entries[i].src2, cdb_valid, cdb_tag, cdb_data);
        end
      end
      if (dispatch) begin
        entries[sel_idx].valid <= 1'b0;
      end
      // The allocated slot was free in registered state, so it never collides
      // with the dispatched slot.
      if (alloc) begin
        entries[free_idx] <= new_entry;
      end
    end
  end

  // ALU handshake: busy tracking and registered dispatch outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= 1'b0;
      alu_start    <= 1'b0;
      alu_opcode   <= '0;
      alu_op1      <= '0;
      alu_op2      <= '0;
      alu_dest_tag <= '0;
    end else begin
      alu_start <= dispatch;
      if (dispatch) begin
        busy         <= 1'b1;
        alu_opcode   <= entries[sel_idx].opcode;
        alu_op1      <= entries[sel_idx].src1.val;
        alu_op2      <= entries[sel_idx].src2.val;
        alu_dest_tag <= entries[sel_idx].dest_tag;
      end else if (alu_done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: scenario tasks plus a dispatch scoreboard.
module tb_alu_rs;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  issue_opcode;
  logic [4:0]  issue_src1_tag;
  logic [4:0]  issue_src2_tag;
  logic [31:0] issue_src1_val;
  logic [31:0] issue_src2_val;
  logic [4:0]  issue_dest_tag;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        alu_start;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [4:0]  alu_dest_tag;
  logic        alu_done;
  logic [2:0]  rs_count;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  d;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   start_cnt = 0;

  alu_rs #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_opcode   (issue_opcode),
    .issue_src1_tag (issue_src1_tag),
    .issue_src2_tag (issue_src2_tag),
    .issue_src1_val (issue_src1_val),
    .issue_src2_val (issue_src2_val),
    .issue_dest_tag (issue_dest_tag),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .alu_start      (alu_start),
    .alu_opcode     (alu_opcode),
    .alu_op1        (alu_op1),
    .alu_op2        (alu_op2),
    .alu_dest_tag   (alu_dest_tag),
    .alu_done       (alu_done),
    .rs_count       (rs_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every dispatch must match the oldest expected operation.
  always @(negedge clk) begin
    if (alu_start === 1'b1) begin
      start_cnt++;
      n_cmp++;
      if (expq.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_start: got op=%h a=%h b=%h d=%0d, required no dispatch",
                 alu_opcode, alu_op1, alu_op2, alu_dest_tag);
      end else begin
        exp_t e;
        e = expq.pop_front();
        if ({alu_opcode, alu_op1, alu_op2, alu_dest_tag} !== {e.op, e.a, e.b, e.d}) begin
          n_err++;
          $display("FAIL sb_dispatch: got op=%h a=%h b=%h d=%0d, required op=%h a=%h b=%h d=%0d",
                   alu_opcode, alu_op1, alu_op2, alu_dest_tag, e.op, e.a, e.b, e.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_op(input logic [5:0] op, input logic [4:0] t1, input logic [31:0] v1,
                          input logic [4:0] t2, input logic [31:0] v2, input logic [4:0] d);
    issue_valid    = 1'b1;
    issue_opcode   = op;
    issue_src1_tag = t1;
    issue_src1_val = v1;
    issue_src2_tag = t2;
    issue_src2_val = v2;
    issue_dest_tag = d;
    tick();
    issue_valid    = 1'b0;
  endtask

  task automatic done_pulse();
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_cmp++;
    if ({alu_start, alu_opcode, alu_op1, alu_op2, alu_dest_tag, rs_count, issue_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got start=%b op=%h a=%h b=%h d=%h cnt=%0d rdy=%b, required all 0",
               alu_start, alu_opcode, alu_op1, alu_op2, alu_dest_tag, rs_count, issue_ready);
    end
    rst = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++;
    if (issue_ready !== 1'b1 || rs_count !== 3'd0) begin
      n_err++;
      $display("FAIL reset_release: got rdy=%b cnt=%0d, required rdy=1 cnt=0", issue_ready, rs_count);
    end
  endtask

  task automatic test_ready_op();
    expq.push_back({6'h20, 32'd5, 32'd7, 5'd10});
    issue_op(6'h20, 5'd0, 32'd5, 5'd0, 32'd7, 5'd10);
    @(negedge clk);
    n_cmp++;
    if (alu_start !== 1'b0 || rs_count !== 3'd1) begin
      n_err++;
      $display("FAIL ready_accept: got start=%b cnt=%0d, required start=0 cnt=1", alu_start, rs_count);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (alu_start !== 1'b1 || alu_op1 !== 32'd5 || alu_op2 !== 32'd7 || alu_dest_tag !== 5'd10) begin
      n_err++;
      $display("FAIL ready_dispatch: got start=%b a=%0d b=%0d d=%0d, required start=1 a=5 b=7 d=10",
               alu_start, alu_op1, alu_op2, alu_dest_tag);
    end
    @(negedge clk);
    n_cmp++;
    if (alu_start !== 1'b0 || alu_op1 !== 32'd5 || rs_count !== 3'd0) begin
      n_err++;
      $display("FAIL ready_pulse: got start=%b a=%0d cnt=%0d, required start=0 a=5 cnt=0",
               alu_start, alu_op1, rs_count);
    end
    done_pulse();
  endtask

  task automatic test_snoop();
    int early;
    early = 0;
    expq.push_back({6'h21, 32'hDEADBEEF, 32'd2, 5'd11});
    issue_op(6'h21, 5'd3, 32'd0, 5'd0, 32'd2, 5'd11);
    repeat (3) begin
      @(negedge clk);
      if (alu_start !== 1'b0) early++;
    end
    n_cmp++;
    if (early != 0) begin
      n_err++;
      $display("FAIL snoop_wait: got %0d early starts, required 0", early);
    end
    cdb_valid = 1'b1;
    cdb_tag   = 5'd3;
    cdb_data  = 32'hDEADBEEF;
    tick();
    cdb_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (alu_start !== 1'b0) begin
      n_err++;
      $display("FAIL snoop_capture_edge: got start=%b, required 0", alu_start);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (alu_start !== 1'b1 || alu_op1 !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL snoop_dispatch: got start=%b a=%h, required start=1 a=deadbeef", alu_start, alu_op1);
    end
    done_pulse();
    // Broadcast in the same cycle as issue.
    expq.push_back({6'h22, 32'h12345678, 32'd9, 5'd12});
    cdb_valid = 1'b1;
    cdb_tag   = 5'd4;
    cdb_data  = 32'h12345678;
    issue_op(6'h22, 5'd4, 32'hFFFFFFFF, 5'd0, 32'd9, 5'd12);
    cdb_valid = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++;
    if (alu_start !== 1'b1 || alu_op1 !== 32'h12345678) begin
      n_err++;
      $display("FAIL bypass_dispatch: got start=%b a=%h, required start=1 a=12345678", alu_start, alu_op1);
    end
    done_pulse();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      expq.push_back({6'(6'h30 + i), 32'hCAFE0000, 32'(100 + i), 5'(20 + i)});
      issue_op(6'(6'h30 + i), 5'd9, 32'd0, 5'd0, 32'(100 + i), 5'(20 + i));
    end
    @(negedge clk);
    n_cmp++;
    if (issue_ready !== 1'b0 || rs_count !== 3'd4) begin
      n_err++;
      $display("FAIL full_state: got rdy=%b cnt=%0d, required rdy=0 cnt=4", issue_ready, rs_count);
    end
    issue_op(6'h3F, 5'd0, 32'd1, 5'd0, 32'd1, 5'd31);
    @(negedge clk);
    n_cmp++;
    if (rs_count !== 3'd4 || alu_start !== 1'b0) begin
      n_err++;
      $display("FAIL full_ignore: got cnt=%0d start=%b, required cnt=4 start=0", rs_count, alu_start);
    end
    cdb_valid = 1'b1;
    cdb_tag   = 5'd9;
    cdb_data  = 32'hCAFE0000;
    tick();
    cdb_valid = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (alu_start !== 1'b1 || alu_dest_tag !== 5'(20 + k) || rs_count !== 3'(3 - k)) begin
        n_err++;
        $display("FAIL full_order_%0d: got start=%b d=%0d cnt=%0d, required start=1 d=%0d cnt=%0d",
                 k, alu_start, alu_dest_tag, rs_count, 20 + k, 3 - k);
      end
      done_pulse();
    end
    @(negedge clk);
    n_cmp++;
    if (rs_count !== 3'd0 || alu_start !== 1'b0) begin
      n_err++;
      $display("FAIL full_drain: got cnt=%0d start=%b, required cnt=0 start=0", rs_count, alu_start);
    end
  endtask

  task automatic test_busy_hold();
    int s0;
    s0 = start_cnt;
    expq.push_back({6'h01, 32'd1, 32'd2, 5'd1});
    expq.push_back({6'h02, 32'd3, 32'd4, 5'd2});
    issue_op(6'h01, 5'd0, 32'd1, 5'd0, 32'd2, 5'd1);
    issue_op(6'h02, 5'd0, 32'd3, 5'd0, 32'd4, 5'd2);
    repeat (6) tick();
    @(negedge clk);
    n_cmp++;
    if (start_cnt - s0 != 1 || rs_count !== 3'd1) begin
      n_err++;
      $display("FAIL busy_hold: got starts=%0d cnt=%0d, required starts=1 cnt=1", start_cnt - s0, rs_count);
    end
    done_pulse();
    @(negedge clk);
    n_cmp++;
    if (alu_start !== 1'b1 || alu_dest_tag !== 5'd2) begin
      n_err++;
      $display("FAIL busy_b2b: got start=%b d=%0d, required start=1 d=2", alu_start, alu_dest_tag);
    end
    done_pulse();
  endtask

  task automatic test_reset_mid();
    int s0;
    int late;
    late = 0;
    expq.push_back({6'h05, 32'd50, 32'd51, 5'd5});
    issue_op(6'h05, 5'd0, 32'd50, 5'd0, 32'd51, 5'd5);
    issue_op(6'h06, 5'd0, 32'd60, 5'd0, 32'd61, 5'd6);
    issue_op(6'h07, 5'd0, 32'd70, 5'd0, 32'd71, 5'd7);
    @(negedge clk);
    n_cmp++;
    if (rs_count !== 3'd2) begin
      n_err++;
      $display("FAIL mid_held: got cnt=%0d, required 2", rs_count);
    end
    rst = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++;
    if (rs_count !== 3'd0 || alu_start !== 1'b0 || issue_ready !== 1'b0 ||
        alu_op1 !== 32'd0 || alu_dest_tag !== 5'd0) begin
      n_err++;
      $display("FAIL mid_reset: got cnt=%0d start=%b rdy=%b a=%0d d=%0d, required all 0",
               rs_count, alu_start, issue_ready, alu_op1, alu_dest_tag);
    end
    rst = 1'b0;
    tick();
    // Busy was cleared by reset, so a fresh op dispatches without any done.
    expq.push_back({6'h08, 32'd80, 32'd81, 5'd8});
    issue_op(6'h08, 5'd0, 32'd80, 5'd0, 32'd81, 5'd8);
    tick();
    @(negedge clk);
    n_cmp++;
    if (alu_start !== 1'b1 || alu_dest_tag !== 5'd8) begin
      n_err++;
      $display("FAIL mid_after_reset: got start=%b d=%0d, required start=1 d=8", alu_start, alu_dest_tag);
    end
    done_pulse();
    s0 = start_cnt;
    done_pulse();
    repeat (3) begin
      @(negedge clk);
      if (alu_start !== 1'b0) late++;
    end
    n_cmp++;
    if (late != 0 || start_cnt != s0 || rs_count !== 3'd0) begin
      n_err++;
      $display("FAIL mid_late_done: got starts=%0d cnt=%0d, required starts=0 cnt=0", late, rs_count);
    end
    n_cmp++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d undispatched expected ops, required 0", expq.size());
    end
  endtask

  initial begin
    rst            = 1'b1;
    issue_valid    = 1'b0;
    issue_opcode   = '0;
    issue_src1_tag = '0;
    issue_src2_tag = '0;
    issue_src1_val = '0;
    issue_src2_val = '0;
    issue_dest_tag = '0;
    cdb_valid      = 1'b0;
    cdb_tag        = '0;
    cdb_data       = '0;
    alu_done       = 1'b0;
    test_reset();
    test_ready_op();
    test_snoop();
    test_full();
    test_busy_hold();
    test_reset_mid();
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
